clip_mem_sequencer: RTL and testbench
=====================================

Name: clip_mem_sequencer

Overview:
- Sequences a single-port clip RAM that holds two clips, clip 0 and clip 1, each CLIP_DEPTH samples.
- Sits between the top-level record/play controller and the clip RAM.
- In record mode, accepts deserialized samples and writes them at incrementing addresses. In play mode, fetches samples on serializer request.
- Tracks the recorded length of each clip and signals completion, which replaces the fixed 2-second timer.

Parameters:
- DATA_W, 8, sample width.
- ADDR_W, 14, per-clip address width.
- CLIP_DEPTH, 16000, max samples per clip (2 s at 8 kHz); must be ≤ 2^ADDR_W.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start_rec  in  1  1-cycle request to record into clip_sel
- start_play  in  1  1-cycle request to play clip_sel
- clip_sel  in  1  clip index; sampled only in IDLE on an accepted start
- abort  in  1  terminate the current record/play
- des_valid  in  1  deserializer sample strobe
- des_data  in  DATA_W  deserializer sample
- ser_req  in  1  serializer requests the next sample
- ser_valid  out  1  1-cycle strobe: ser_data is valid
- ser_data  out  DATA_W  sample to serializer
- mem_addr  out  ADDR_W+1  {clip, offset}
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_re
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse at the end of record/play
- req_drop  out  1  sticky: a ser_req arrived while a read was outstanding; cleared on the next accepted start

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; cnt=0; len0=len1=0; clip register=0.
  - All outputs 0, including mem_addr, ser_data and req_drop.
- All outputs are registered.
- States: IDLE, REC, PLAY, RD_WAIT, FIN.
- IDLE:
  - start_rec=1 → latch clip_sel, cnt=0, clear req_drop, go REC.
  - Otherwise start_play=1 → same latch/clear, go PLAY. start_rec wins if both are asserted.
  - des_valid and ser_req are ignored.
- REC:
  - On des_valid: next cycle mem_we=1, mem_addr={clip,cnt}, mem_wdata=des_data; then cnt increments.
  - When the write at cnt=CLIP_DEPTH-1 issues: len[clip]=CLIP_DEPTH, go FIN.
  - abort=1 → len[clip]=cnt (samples already written). If des_valid arrives in the same cycle, abort wins and the sample is dropped. Go FIN.
  - start_rec and start_play are ignored while busy.
- PLAY:
  - On entry, len[clip]=0 → go FIN next cycle with no RAM access.
  - On ser_req: next cycle mem_re=1, mem_addr={clip,cnt}, go RD_WAIT.
  - abort → FIN.
- RD_WAIT:
  - Capture mem_rdata into ser_data; ser_valid=1 the following cycle; cnt increments.
  - If the new cnt equals len[clip] → FIN, else → PLAY.
  - A ser_req arriving in RD_WAIT is dropped and sets req_drop.
  - An abort in RD_WAIT completes the in-flight sample (ser_valid still fires), then goes FIN.
- FIN: done=1 for exactly 1 cycle, busy=1, then IDLE.
- Latency:
  - des_valid → mem_we: 1 cycle.
  - ser_req → mem_re: 1 cycle.
  - ser_req → ser_valid: 3 cycles.
- Widths:
  - cnt is ADDR_W+1 bits and never exceeds CLIP_DEPTH; no wrap.
  - len registers are ADDR_W+1 bits.
- Recording a clip overwrites only that clip's len; the other clip's len is retained.
- Reset asserted mid-operation → immediate return to IDLE. Both lens clear, so recorded clips read as empty.

Test Plan:
- Reset, then start_rec with clip_sel=1 and 5 des_valid pulses (data 0x11..0x15), then abort:
  - mem_we hits addresses 0x4000..0x4004 with data 0x11..0x15.
  - len1=5; done pulses once; busy returns to 0.
- Then start_play with clip_sel=1 and 6 spaced ser_req pulses:
  - ser_data = 0x11..0x15, each ser_valid exactly 3 cycles after its ser_req.
  - done after the 5th sample; the 6th ser_req is ignored in IDLE.
- start_play on clip 0 after reset → no mem_re; done pulses 2 cycles after start; busy high only for those cycles.
- Full record with CLIP_DEPTH=16 and 20 des_valid pulses:
  - Exactly 16 writes, addresses 0x0000..0x000F.
  - done after the 16th write; the remaining 4 samples are ignored; len0=16.
- start_rec and start_play asserted in the same cycle → REC entered. A ser_req during RD_WAIT in a later play sets req_drop, which stays 1 until the next start.
- reset_n pulsed low mid-REC → all outputs 0 asynchronously; a following start_play on the same clip yields immediate done (len=0).

Source files
------------

// File: rtl/clip_mem_sequencer_if.sv
// Bundle of control, deserializer, serializer and clip-RAM signals around
// clip_mem_sequencer. The controller/bench side is master; the sequencer is slave.
interface clip_mem_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
);
    logic              start_rec;
    logic              start_play;
    logic              clip_sel;
    logic              abort;
    logic              des_valid;
    logic [DATA_W-1:0] des_data;
    logic              ser_req;
    logic              ser_valid;
    logic [DATA_W-1:0] ser_data;
    logic [ADDR_W:0]   mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic              req_drop;

    modport master (
        output start_rec, start_play, clip_sel, abort,
        output des_valid, des_data, ser_req, mem_rdata,
        input  ser_valid, ser_data, mem_addr, mem_we, mem_re, mem_wdata,
        input  busy, done, req_drop
    );

    modport slave (
        input  start_rec, start_play, clip_sel, abort,
        input  des_valid, des_data, ser_req, mem_rdata,
        output ser_valid, ser_data, mem_addr, mem_we, mem_re, mem_wdata,
        output busy, done, req_drop
    );
endinterface

// File: rtl/clip_mem_sequencer.sv
// Record/play sequencer for a single-port RAM holding two clips; tracks each
// clip's recorded length and pulses done when a record or playback finishes.
module clip_mem_sequencer #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 14,
    parameter int CLIP_DEPTH = 16000
) (
    input logic                 clock,
    input logic                 reset_n,
    clip_mem_sequencer_if.slave bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CLIP_DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(CLIP_DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REC     = 3'd1,
        ST_PLAY    = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_FIN     = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [CNT_W-1:0]  len0_r, len0_s;
    logic [CNT_W-1:0]  len1_r, len1_s;
    logic [CNT_W-1:0]  cur_len_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic [CNT_W-1:0]  cur_addr_s;
    logic [CNT_W-1:0]  len_val_s;
    logic              len_we_s;
    logic              clip_r, clip_s;
    logic              rd_phase_r, rd_phase_s;
    logic              abort_pend_r, abort_pend_s;
    logic              mem_we_r, mem_we_s;
    logic              mem_re_r, mem_re_s;
    logic [CNT_W-1:0]  mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic              ser_valid_r, ser_valid_s;
    logic [DATA_W-1:0] ser_data_r, ser_data_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              req_drop_r, req_drop_s;

    assign cur_len_s  = clip_r ? len1_r : len0_r;
    assign cnt_inc_s  = cnt_r + ONE_C;
    assign cur_addr_s = {clip_r, cnt_r[ADDR_W-1:0]};

    // Next-state and next-output logic; every output is taken from a register.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        clip_s       = clip_r;
        rd_phase_s   = rd_phase_r;
        abort_pend_s = abort_pend_r;
        req_drop_s   = req_drop_r;
        len_we_s     = 1'b0;
        len_val_s    = cnt_r;
        mem_we_s     = 1'b0;
        mem_re_s     = 1'b0;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        ser_valid_s  = 1'b0;
        ser_data_s   = ser_data_r;
        len0_s       = len0_r;
        len1_s       = len1_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.start_rec) begin
                    clip_s     = bus.clip_sel;
                    cnt_s      = ZERO_C;
                    req_drop_s = 1'b0;
                    state_s    = ST_REC;
                end else if (bus.start_play) begin
                    clip_s     = bus.clip_sel;
                    cnt_s      = ZERO_C;
                    req_drop_s = 1'b0;
                    state_s    = ST_PLAY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REC: begin
                // abort outranks a coincident sample: that sample is not written
                if (bus.abort) begin
                    len_we_s  = 1'b1;
                    len_val_s = cnt_r;
                    state_s   = ST_FIN;
                end else if (bus.des_valid) begin
                    mem_we_s    = 1'b1;
                    mem_addr_s  = cur_addr_s;
                    mem_wdata_s = bus.des_data;
                    cnt_s       = cnt_inc_s;
                    if (cnt_r == LAST_C) begin
                        len_we_s  = 1'b1;
                        len_val_s = DEPTH_C;
                        state_s   = ST_FIN;
                    end else begin
                        state_s = ST_REC;
                    end
                end else begin
                    state_s = ST_REC;
                end
            end
            ST_PLAY: begin
                if (bus.abort) begin
                    state_s = ST_FIN;
                end else if (cur_len_s == ZERO_C) begin
                    state_s = ST_FIN;
                end else if (bus.ser_req) begin
                    mem_re_s     = 1'b1;
                    mem_addr_s   = cur_addr_s;
                    rd_phase_s   = 1'b0;
                    abort_pend_s = 1'b0;
                    state_s      = ST_RD_WAIT;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_RD_WAIT: begin
                if (bus.ser_req) begin
                    req_drop_s = 1'b1;
                end else begin
                    req_drop_s = req_drop_r;
                end
                // first cycle: RAM is reading; second cycle: mem_rdata is valid
                if (!rd_phase_r) begin
                    rd_phase_s   = 1'b1;
                    abort_pend_s = abort_pend_r | bus.abort;
                    state_s      = ST_RD_WAIT;
                end else begin
                    ser_data_s   = bus.mem_rdata;
                    ser_valid_s  = 1'b1;
                    cnt_s        = cnt_inc_s;
                    rd_phase_s   = 1'b0;
                    abort_pend_s = 1'b0;
                    if (bus.abort || abort_pend_r || (cnt_inc_s == cur_len_s)) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (len_we_s && clip_r) begin
            len1_s = len_val_s;
        end else if (len_we_s) begin
            len0_s = len_val_s;
        end else begin
            len0_s = len0_r;
        end

        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_FIN);
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counters, clip lengths and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r        <= ZERO_C;
            len0_r       <= ZERO_C;
            len1_r       <= ZERO_C;
            clip_r       <= 1'b0;
            rd_phase_r   <= 1'b0;
            abort_pend_r <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_re_r     <= 1'b0;
            mem_addr_r   <= ZERO_C;
            mem_wdata_r  <= {DATA_W{1'b0}};
            ser_valid_r  <= 1'b0;
            ser_data_r   <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            req_drop_r   <= 1'b0;
        end else begin
            cnt_r        <= cnt_s;
            len0_r       <= len0_s;
            len1_r       <= len1_s;
            clip_r       <= clip_s;
            rd_phase_r   <= rd_phase_s;
            abort_pend_r <= abort_pend_s;
            mem_we_r     <= mem_we_s;
            mem_re_r     <= mem_re_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            ser_valid_r  <= ser_valid_s;
            ser_data_r   <= ser_data_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            req_drop_r   <= req_drop_s;
        end
    end

    assign bus.mem_we    = mem_we_r;
    assign bus.mem_re    = mem_re_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.ser_valid = ser_valid_r;
    assign bus.ser_data  = ser_data_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.req_drop  = req_drop_r;
endmodule

// File: tb/tb_clip_mem_sequencer.sv
// Self-checking bench for clip_mem_sequencer: directed sequences, a vector table
// and random record/play episodes checked against per-clip sample queues.
module tb_clip_mem_sequencer;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 16;

    typedef struct packed {
        logic       is_rec;
        logic       clip;
        logic [7:0] n;
        logic [7:0] exp_n;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   re_cnt  = 0;
    int   done_cnt = 0;

    logic [ADDR_W:0]   wr_addr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    logic [DATA_W-1:0] rd_data_q[$];
    int                rd_cyc_q[$];
    int                req_cyc_q[$];
    logic [DATA_W-1:0] sent_q[$];
    logic [DATA_W-1:0] model0[$];
    logic [DATA_W-1:0] model1[$];
    logic [DATA_W-1:0] ram [0:(2**(ADDR_W+1))-1];
    vec_t              tbl [0:8];

    clip_mem_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    clip_mem_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLIP_DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Clip RAM: read data valid the cycle after mem_re.
    always @(posedge clock) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
    end

    initial begin
        forever begin
            @(negedge clock);
            if (bus.mem_we) begin
                wr_addr_q.push_back(bus.mem_addr);
                wr_data_q.push_back(bus.mem_wdata);
            end
            if (bus.mem_re) re_cnt = re_cnt + 1;
            if (bus.ser_valid) begin
                rd_data_q.push_back(bus.ser_data);
                rd_cyc_q.push_back(cyc);
            end
            if (bus.done) done_cnt = done_cnt + 1;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_data_q.delete();
        rd_cyc_q.delete();
        req_cyc_q.delete();
        re_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            step();
            n++;
        end
        step();
        check({name, " returns idle"}, int'(bus.busy), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step();
        model0.delete();
        model1.delete();
    endtask

    function automatic logic [DATA_W-1:0] model_at(input logic clip, input int i);
        if (clip) return (i < model1.size()) ? model1[i] : 8'h00;
        return (i < model0.size()) ? model0[i] : 8'h00;
    endfunction

    function automatic int model_size(input logic clip);
        return clip ? model1.size() : model0.size();
    endfunction

    task automatic do_rec(input logic clip, input int n, input int gap_max, input logic [7:0] base);
        clear_logs();
        sent_q.delete();
        bus.clip_sel  = clip;
        bus.start_rec = 1'b1;
        step();
        bus.start_rec = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.des_valid = 1'b1;
            bus.des_data  = base + 8'(i);
            sent_q.push_back(bus.des_data);
            step();
            bus.des_valid = 1'b0;
            step(int'($urandom_range(gap_max, 0)));
        end
        if (n < DEPTH) begin
            bus.abort = 1'b1;
            step();
            bus.abort = 1'b0;
        end
        wait_idle("rec");
    endtask

    task automatic check_rec(input string name, input logic clip, input int exp_n);
        check({name, " write count"}, wr_addr_q.size(), exp_n);
        check({name, " done pulses"}, done_cnt, 1);
        for (int i = 0; i < exp_n && i < wr_addr_q.size(); i++) begin
            check({name, " write addr"}, int'(wr_addr_q[i]), (int'(clip) << ADDR_W) + i);
            check({name, " write data"}, int'(wr_data_q[i]), int'(sent_q[i]));
        end
        if (clip) model1.delete();
        else model0.delete();
        for (int i = 0; i < exp_n && i < sent_q.size(); i++) begin
            if (clip) model1.push_back(sent_q[i]);
            else model0.push_back(sent_q[i]);
        end
    endtask

    task automatic do_play(input logic clip, input int nreq, input int gap_min,
                           input int gap_max, input logic do_abort);
        clear_logs();
        bus.clip_sel   = clip;
        bus.start_play = 1'b1;
        step();
        bus.start_play = 1'b0;
        for (int i = 0; i < nreq; i++) begin
            bus.ser_req = 1'b1;
            req_cyc_q.push_back(cyc);
            step();
            bus.ser_req = 1'b0;
            step(int'($urandom_range(gap_max, gap_min)));
        end
        if (do_abort) begin
            bus.abort = 1'b1;
            step();
            bus.abort = 1'b0;
        end
        wait_idle("play");
    endtask

    task automatic check_play(input string name, input logic clip, input int exp_n);
        check({name, " sample count"}, rd_data_q.size(), exp_n);
        check({name, " read strobes"}, re_cnt, exp_n);
        check({name, " done pulses"}, done_cnt, 1);
        check({name, " req_drop"}, int'(bus.req_drop), 0);
        for (int i = 0; i < exp_n && i < rd_data_q.size(); i++) begin
            check({name, " sample data"}, int'(rd_data_q[i]), int'(model_at(clip, i)));
            check({name, " req to valid"}, rd_cyc_q[i] - req_cyc_q[i], 3);
        end
    endtask

    initial begin
        logic rclip;
        int   rn;
        int   rlen;

        bus.start_rec  = 1'b0;
        bus.start_play = 1'b0;
        bus.clip_sel   = 1'b0;
        bus.abort      = 1'b0;
        bus.des_valid  = 1'b0;
        bus.des_data   = 8'h00;
        bus.ser_req    = 1'b0;

        tbl[0] = '{1'b1, 1'b0, 8'd7,  8'd7};
        tbl[1] = '{1'b1, 1'b1, 8'd3,  8'd3};
        tbl[2] = '{1'b0, 1'b0, 8'd9,  8'd7};
        tbl[3] = '{1'b0, 1'b1, 8'd4,  8'd3};
        tbl[4] = '{1'b1, 1'b1, 8'd18, 8'd16};
        tbl[5] = '{1'b0, 1'b0, 8'd8,  8'd7};
        tbl[6] = '{1'b0, 1'b1, 8'd17, 8'd16};
        tbl[7] = '{1'b1, 1'b0, 8'd0,  8'd0};
        tbl[8] = '{1'b0, 1'b0, 8'd2,  8'd0};

        step(3);
        check("reset ser/status", int'({bus.ser_valid, bus.ser_data, bus.done, bus.busy, bus.req_drop}), 0);
        check("reset mem port", int'({bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata}), 0);
        reset_n = 1'b1;
        step(2);

        // Record five samples into clip 1, abort, then play them back.
        do_rec(1'b1, 5, 1, 8'h11);
        check_rec("rec clip1 abort", 1'b1, 5);
        do_play(1'b1, 6, 3, 5, 1'b0);
        check_play("play clip1", 1'b1, 5);
        check("play clip1 last sample", (rd_data_q.size() == 5) ? int'(rd_data_q[4]) : -1, 8'h15);

        // Empty clip after reset: done two cycles after start, no RAM access.
        do_reset();
        clear_logs();
        bus.clip_sel   = 1'b0;
        bus.start_play = 1'b1;
        step();
        bus.start_play = 1'b0;
        check("empty play c1 busy", int'(bus.busy), 1);
        check("empty play c1 done", int'(bus.done), 0);
        step();
        check("empty play c2 busy", int'(bus.busy), 1);
        check("empty play c2 done", int'(bus.done), 1);
        step();
        check("empty play c3 busy", int'(bus.busy), 0);
        check("empty play c3 done", int'(bus.done), 0);
        check("empty play reads", re_cnt, 0);

        // Full clip: 20 back-to-back samples, only 16 written.
        do_rec(1'b0, 20, 0, 8'h40);
        check_rec("full rec", 1'b0, DEPTH);
        do_play(1'b0, DEPTH, 2, 2, 1'b0);
        check_play("full play", 1'b0, DEPTH);

        // Both starts together: record wins.
        clear_logs();
        sent_q.delete();
        bus.clip_sel   = 1'b0;
        bus.start_rec  = 1'b1;
        bus.start_play = 1'b1;
        step();
        bus.start_rec  = 1'b0;
        bus.start_play = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.des_valid = 1'b1;
            bus.des_data  = 8'hA0 + 8'(i);
            sent_q.push_back(bus.des_data);
            step();
        end
        bus.des_valid = 1'b0;
        bus.abort     = 1'b1;
        step();
        bus.abort     = 1'b0;
        wait_idle("dual start");
        check_rec("dual start rec", 1'b0, 2);

        // A request held into the read wait is dropped and sticks until the next start.
        clear_logs();
        bus.clip_sel   = 1'b0;
        bus.start_play = 1'b1;
        step();
        bus.start_play = 1'b0;
        check("drop pre req_drop", int'(bus.req_drop), 0);
        bus.ser_req = 1'b1;
        step();
        step();
        bus.ser_req = 1'b0;
        check("drop req_drop set", int'(bus.req_drop), 1);
        step(3);
        bus.ser_req = 1'b1;
        step();
        bus.ser_req = 1'b0;
        wait_idle("drop play");
        check("drop samples", rd_data_q.size(), 2);
        check("drop sample0", (rd_data_q.size() > 0) ? int'(rd_data_q[0]) : -1, 8'hA0);
        check("drop sample1", (rd_data_q.size() > 1) ? int'(rd_data_q[1]) : -1, 8'hA1);
        check("drop req_drop held", int'(bus.req_drop), 1);
        bus.start_play = 1'b1;
        step();
        bus.start_play = 1'b0;
        check("drop cleared by start", int'(bus.req_drop), 0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        wait_idle("drop abort");

        // Reset in the middle of a record clears outputs at once and empties both clips.
        clear_logs();
        bus.clip_sel  = 1'b1;
        bus.start_rec = 1'b1;
        step();
        bus.start_rec = 1'b0;
        bus.des_valid = 1'b1;
        bus.des_data  = 8'h5A;
        step(2);
        check("mid-rec write active", int'(bus.mem_we), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async reset status", int'({bus.busy, bus.done, bus.ser_valid, bus.ser_data, bus.req_drop}), 0);
        check("async reset mem", int'({bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata}), 0);
        bus.des_valid = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        model0.delete();
        model1.delete();
        do_play(1'b1, 2, 2, 3, 1'b0);
        check_play("post-reset clip1", 1'b1, 0);
        do_play(1'b0, 1, 2, 3, 1'b0);
        check_play("post-reset clip0", 1'b0, 0);

        for (int v = 0; v < 9; v++) begin
            if (tbl[v].is_rec) begin
                do_rec(tbl[v].clip, int'(tbl[v].n), 1, 8'(v * 16 + 3));
                check_rec($sformatf("vec%0d rec", v), tbl[v].clip, int'(tbl[v].exp_n));
            end else begin
                do_play(tbl[v].clip, int'(tbl[v].n), 2, 4, int'(tbl[v].n) < int'(tbl[v].exp_n));
                check_play($sformatf("vec%0d play", v), tbl[v].clip, int'(tbl[v].exp_n));
            end
        end

        for (int e = 0; e < 24; e++) begin
            rclip = 1'($urandom_range(1, 0));
            rn    = int'($urandom_range(20, 0));
            if ($urandom_range(1, 0) == 1) begin
                do_rec(rclip, rn, 2, 8'($urandom));
                check_rec($sformatf("rand%0d rec", e), rclip, (rn < DEPTH) ? rn : DEPTH);
            end else begin
                rlen = model_size(rclip);
                do_play(rclip, rn, 2, 4, rn < rlen);
                check_play($sformatf("rand%0d play", e), rclip, (rn < rlen) ? rn : rlen);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
